// File: rtl/ma_stage.sv
// Memory-access stage of the SimpleRISC pipeline.
// Issues ld/st over a request/acknowledge data port, stalls upstream until the
// access finishes (or times out) and registers results toward MA/RW.
module ma_stage #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [4:0]  OP_LD          = 5'b01110,
    parameter logic [4:0]  OP_ST          = 5'b01111,
    parameter logic [31:0] NOP_INST       = 32'h68000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Result_In,
    input  logic [31:0] Inst_In,
    input  logic [31:0] Operand_B_In,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        Stall_Out,
    output logic [31:0] Result_Out,
    output logic [31:0] Ld_Result_Out,
    output logic [31:0] Inst_Out,
    output logic        Mem_Err_Out
);

    // Counter is wide enough to hold TIMEOUT_CYCLES-1 even for tiny timeouts.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_ld_buf;
    logic [31:0]     r_result;
    logic [31:0]     r_ld_result;
    logic [31:0]     r_inst;
    logic            r_err;

    logic [4:0]      w_opcode;
    logic            w_mem_op;
    logic            w_misaligned;
    logic            w_start;
    logic            w_timeout;

    assign w_opcode     = Inst_In[31:27];
    assign w_mem_op     = (w_opcode == OP_LD) || (w_opcode == OP_ST);
    assign w_misaligned = w_mem_op && (Result_In[1:0] != 2'b00);
    // A well-formed memory op in IDLE must stall already in its first cycle,
    // otherwise upstream would advance before the request is even issued.
    assign w_start      = (r_state == S_IDLE) && w_mem_op && !w_misaligned;
    assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign Stall_Out    = w_start || (r_state == S_REQ);

    assign mem_req       = r_req;
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign Result_Out    = r_result;
    assign Ld_Result_Out = r_ld_result;
    assign Inst_Out      = r_inst;
    assign Mem_Err_Out   = r_err;

    // Access FSM together with the memory-port and MA/RW output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_ld_buf    <= 32'd0;
            r_result    <= 32'd0;
            r_ld_result <= 32'd0;
            r_inst      <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr      <= Result_In;
                        r_wdata     <= Operand_B_In;
                        r_we        <= (w_opcode == OP_ST);
                        r_req       <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_REQ;
                        r_result    <= 32'd0;
                        r_ld_result <= 32'd0;
                        r_inst      <= NOP_INST;
                    end else begin
                        // Non-memory or misaligned: pass straight through.
                        r_result    <= Result_In;
                        r_inst      <= Inst_In;
                        r_ld_result <= 32'd0;
                        if (w_misaligned) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_result    <= 32'd0;
                    r_ld_result <= 32'd0;
                    r_inst      <= NOP_INST;
                    // Ack is checked first so a last-cycle ack still succeeds.
                    if (mem_ack) begin
                        r_ld_buf <= r_we ? 32'd0 : mem_rdata;
                        r_req    <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        r_ld_buf <= 32'd0;
                        r_req    <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Upstream advances on this same edge; the held inputs
                    // still describe the completed instruction.
                    r_result    <= Result_In;
                    r_inst      <= Inst_In;
                    r_ld_result <= r_ld_buf;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access (MA) stage of the 32-bit SimpleRISC pipeline, directly downstream of the EX/MA pipeline register.
- Consumes the ALU result, the instruction word and operand B, then performs ld/st through a variable-latency request/acknowledge data-memory port.
- Stalls the upstream pipeline until the access completes, then registers the results toward the MA/RW register and writeback.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ waiting for mem_ack before abort.
- OP_LD, 5'b01110, opcode (Inst[31:27]) of load.
- OP_ST, 5'b01111, opcode of store.
- NOP_INST, 32'h68000000, bubble instruction inserted while stalled.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- Result_In  input  32  ALU result from EX/MA; the byte address for ld/st.
- Inst_In  input  32  instruction word from EX/MA.
- Operand_B_In  input  32  store data from EX/MA.
- mem_rdata  input  32  read data, valid when mem_ack=1.
- mem_ack  input  1  one-cycle access completion from data memory.
- mem_req  output  1  registered request, held high until ack or timeout.
- mem_we  output  1  1=store, 0=load; valid with mem_req.
- mem_addr  output  32  registered Result_In, valid with mem_req.
- mem_wdata  output  32  registered Operand_B_In, valid with mem_req.
- Stall_Out  output  1  combinational; 1 freezes PC, IF/OF/EX stages and EX/MA register.
- Result_Out  output  32  registered ALU result to MA/RW.
- Ld_Result_Out  output  32  registered load data to MA/RW.
- Inst_Out  output  32  registered instruction to MA/RW.
- Mem_Err_Out  output  1  sticky error flag for misaligned access or timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; Result_Out=0, Ld_Result_Out=0, Inst_Out=0; Mem_Err_Out=0; timeout counter=0. An in-flight request is dropped immediately and a late mem_ack after reset is ignored.
- mem_op = (Inst_In[31:27]==OP_LD or OP_ST); misaligned = mem_op and Result_In[1:0]!=0.
- FSM states are IDLE, REQ and DONE.
- IDLE, with mem_op and not misaligned:
  - Stall_Out=1.
  - At the edge: latch mem_addr/mem_wdata/mem_we, set mem_req=1, go to REQ, clear the counter.
- IDLE, with a non-memory instruction, or a misaligned access:
  - Stall_Out=0; no memory traffic.
  - Output register loads Result_In, Inst_In and Ld_Result_Out=0.
  - A misaligned access also sets Mem_Err_Out=1.
- REQ:
  - Stall_Out=1; the counter increments each cycle.
  - mem_ack=1: capture mem_rdata into the load buffer (loads only; stores buffer 0), drop mem_req, go to DONE.
  - Counter reaching TIMEOUT_CYCLES-1 without ack: drop mem_req, load buffer=0, Mem_Err_Out=1, go to DONE.
  - mem_ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - Stall_Out=0.
  - At the edge: Result_Out<=Result_In, Inst_Out<=Inst_In, Ld_Result_Out<=load buffer; go to IDLE.
  - Upstream advances on the same edge, so the instruction is never re-issued.
- Output register while Stall_Out=1: Inst_Out<=NOP_INST, Result_Out<=0, Ld_Result_Out<=0, i.e. a bubble each stalled cycle.
- mem_ack outside REQ is ignored.
- Latency:
  - Non-memory instruction: 1 cycle, no stall.
  - Memory instruction with ack in the first REQ cycle: 2 stall cycles, then the DONE cycle.
  - Every additional wait cycle adds 1 stall cycle.
- Inputs are held stable by upstream while Stall_Out=1; the block samples them again in DONE.

Test Plan:
- Reset, then add (Inst_In=32'h00000000), Result_In=5 -> Stall_Out=0 throughout; next edge Result_Out=5, Inst_Out=0, mem_req never asserted.
- ld (Inst_In[31:27]=01110), Result_In=32'h40, ack one cycle after mem_req rises with mem_rdata=32'hDEADBEEF -> mem_req=1, mem_we=0, mem_addr=32'h40; Stall_Out high 2 cycles; after DONE, Ld_Result_Out=32'hDEADBEEF, Inst_Out=the ld word; bubble cycles show Inst_Out=32'h68000000.
- st, Result_In=32'h80, Operand_B_In=32'h12345678, ack after 3 wait cycles -> mem_we=1, mem_wdata=32'h12345678; Stall_Out high 5 cycles; Ld_Result_Out=0.
- ld with no ack (TIMEOUT_CYCLES=16) -> mem_req high exactly 16 cycles, then Mem_Err_Out=1 (sticky), Ld_Result_Out=0, pipeline resumes.
- st with Result_In=32'h82 -> no mem_req, Stall_Out=0, Mem_Err_Out=1 next edge.
- rst_n pulsed low mid-REQ, then mem_ack arrives -> mem_req=0 and all outputs 0 immediately; ack ignored; state IDLE.
